anticipator_index_stage: RTL and testbench



---
 rtl/anticipator_index_stage.sv | 211 +++++++++++++++++++++
 tb/tb_anticipator_index_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/anticipator_index_stage.sv
// anticipator_index_stage
// Pipeline stage directly upstream of the 4-port anticipator RAM.
//   S1 registers an accepted 4-slot bundle and drives the four 12-bit RAM addresses.
//   S2 registers the returned 2-bit predictions and derives per-slot take flags.
//   An in-order tracking queue records {tag, take mask} of every emitted bundle. Execute-stage
//   resolutions retire the queue head and are compared against it to count mispredicts.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   in_valid_i / in_ready_o         input bundle handshake
//   in_slot_en_i, in_hi_i,
//   in_op_i, in_lo_i                per-slot enable and address nibbles (slot n at [4n+3:4n])
//   readN_addr_o / readN_data_i     anticipator RAM read ports (data combinational from address)
//   out_valid_o / out_ready_i       prediction bundle handshake
//   out_pred_o, out_take_o,
//   out_first_o, out_any_o,
//   out_tag_o                       prediction bundle contents
//   res_valid_i, res_tag_i,
//   res_taken_i                     resolution of the oldest outstanding bundle
//   pending_cnt_o                   outstanding queue entries, 0..QDEPTH
//   mispredict_cnt_o                saturating mispredict count
//   err_o                           sticky protocol error
module anticipator_index_stage #(
    parameter int unsigned QDEPTH = 8,
    parameter int unsigned CNTW   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [3:0]                in_slot_en_i,
    input  logic [15:0]               in_hi_i,
    input  logic [15:0]               in_op_i,
    input  logic [15:0]               in_lo_i,
    output logic [11:0]               read0_addr_o,
    output logic [11:0]               read1_addr_o,
    output logic [11:0]               read2_addr_o,
    output logic [11:0]               read3_addr_o,
    input  logic [1:0]                read0_data_i,
    input  logic [1:0]                read1_data_i,
    input  logic [1:0]                read2_data_i,
    input  logic [1:0]                read3_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [7:0]                out_pred_o,
    output logic [3:0]                out_take_o,
    output logic [1:0]                out_first_o,
    output logic                      out_any_o,
    output logic [$clog2(QDEPTH)-1:0] out_tag_o,
    input  logic                      res_valid_i,
    input  logic [$clog2(QDEPTH)-1:0] res_tag_i,
    input  logic [3:0]                res_taken_i,
    output logic [$clog2(QDEPTH):0]   pending_cnt_o,
    output logic [CNTW-1:0]           mispredict_cnt_o,
    output logic                      err_o
);

    localparam int unsigned TagW = $clog2(QDEPTH);
    localparam logic [TagW:0] QFull = (TagW + 1)'(QDEPTH);

    // S1: registered bundle
    logic        s1_valid_q;
    logic [3:0]  s1_en_q;
    logic [15:0] s1_hi_q;
    logic [15:0] s1_op_q;
    logic [15:0] s1_lo_q;

    // S2: registered predictions
    logic        s2_valid_q;
    logic [7:0]  s2_pred_q;
    logic [3:0]  s2_take_q;

    // Tracking queue; the tag of an entry equals its slot index because both the tail pointer
    // and the next tag advance by one per push and both restart at 0 on reset.
    logic [3:0]      q_take_q [QDEPTH];
    logic [TagW-1:0] head_q;
    logic [TagW-1:0] tail_q;
    logic [TagW:0]   cnt_q;

    logic [CNTW-1:0] mis_q;
    logic            err_q;

    logic        s2_free;
    logic        s1_adv;
    logic        in_fire;
    logic        out_fire;
    logic        pop;
    logic        res_err;
    logic        mispredict;
    logic [11:0] addr [4];
    logic [7:0]  rd_data;
    logic [7:0]  pred_d;
    logic [3:0]  take_d;

    // Flow control
    always_comb begin
        out_valid_o = s2_valid_q && (cnt_q < QFull);
        out_fire    = out_valid_o && out_ready_i;
        s2_free     = !s2_valid_q || out_fire;
        s1_adv      = s1_valid_q && s2_free;
        in_ready_o  = !s1_valid_q || s1_adv;
        in_fire     = in_valid_i && in_ready_o;
    end

    // Address formation and prediction masking
    always_comb begin
        rd_data = {read3_data_i, read2_data_i, read1_data_i, read0_data_i};
        pred_d  = '0;
        take_d  = '0;
        for (int n = 0; n < 4; n++) begin
            addr[n] = '0;
            if (s1_valid_q && s1_en_q[n]) begin
                addr[n] = {s1_hi_q[4*n +: 4], s1_op_q[4*n +: 4], s1_lo_q[4*n +: 4]};
            end
            if (s1_en_q[n]) begin
                pred_d[2*n +: 2] = rd_data[2*n +: 2];
                take_d[n]        = &rd_data[2*n +: 2];
            end
        end
    end

    assign read0_addr_o = addr[0];
    assign read1_addr_o = addr[1];
    assign read2_addr_o = addr[2];
    assign read3_addr_o = addr[3];

    // Output bundle decode from the registered take flags
    always_comb begin
        out_pred_o  = s2_pred_q;
        out_take_o  = s2_take_q;
        out_any_o   = |s2_take_q;
        out_first_o = 2'd0;
        for (int n = 3; n >= 0; n--) begin
            if (s2_take_q[n]) begin
                out_first_o = 2'(n);
            end
        end
    end

    // Resolution; occupancy is judged at cycle start, so an empty queue never pops even if a
    // push lands in the same cycle.
    always_comb begin
        pop        = res_valid_i && (cnt_q != '0);
        res_err    = res_valid_i && ((cnt_q == '0) || (res_tag_i != head_q));
        mispredict = pop && (res_taken_i != q_take_q[head_q]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_en_q    <= '0;
            s1_hi_q    <= '0;
            s1_op_q    <= '0;
            s1_lo_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_pred_q  <= '0;
            s2_take_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            mis_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            if (in_ready_o) begin
                s1_valid_q <= in_valid_i;
            end
            if (in_fire) begin
                s1_en_q <= in_slot_en_i;
                s1_hi_q <= in_hi_i;
                s1_op_q <= in_op_i;
                s1_lo_q <= in_lo_i;
            end
            if (s2_free) begin
                s2_valid_q <= s1_valid_q;
            end
            if (s1_adv) begin
                s2_pred_q <= pred_d;
                s2_take_q <= take_d;
            end
            if (out_fire) begin
                tail_q <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            if (out_fire && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!out_fire && pop) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (mispredict && (mis_q != '1)) begin
                mis_q <= mis_q + 1'b1;
            end
            if (res_err) begin
                err_q <= 1'b1;
            end
        end
    end

    // Queue storage needs no reset: entries are only read between a push and its pop.
    always_ff @(posedge clk) begin
        if (!rst && out_fire) begin
            q_take_q[tail_q] <= s2_take_q;
        end
    end

    assign out_tag_o        = tail_q;
    assign pending_cnt_o    = cnt_q;
    assign mispredict_cnt_o = mis_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_anticipator_index_stage.sv
module tb_anticipator_index_stage;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready;
    logic [3:0]  in_slot_en;
    logic [15:0] in_hi, in_op, in_lo;
    logic [11:0] ra0, ra1, ra2, ra3;
    logic [1:0]  rd0, rd1, rd2, rd3;
    logic        out_valid, out_ready;
    logic [7:0]  out_pred;
    logic [3:0]  out_take;
    logic [1:0]  out_first;
    logic        out_any;
    logic [2:0]  out_tag;
    logic        res_valid;
    logic [2:0]  res_tag;
    logic [3:0]  res_taken;
    logic [3:0]  pending_cnt;
    logic [15:0] mispredict_cnt;
    logic        err;

    anticipator_index_stage #(.QDEPTH(8), .CNTW(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready),
        .in_slot_en_i     (in_slot_en),
        .in_hi_i          (in_hi),
        .in_op_i          (in_op),
        .in_lo_i          (in_lo),
        .read0_addr_o     (ra0),
        .read1_addr_o     (ra1),
        .read2_addr_o     (ra2),
        .read3_addr_o     (ra3),
        .read0_data_i     (rd0),
        .read1_data_i     (rd1),
        .read2_data_i     (rd2),
        .read3_data_i     (rd3),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_pred_o       (out_pred),
        .out_take_o       (out_take),
        .out_first_o      (out_first),
        .out_any_o        (out_any),
        .out_tag_o        (out_tag),
        .res_valid_i      (res_valid),
        .res_tag_i        (res_tag),
        .res_taken_i      (res_taken),
        .pending_cnt_o    (pending_cnt),
        .mispredict_cnt_o (mispredict_cnt),
        .err_o            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Anticipator RAM contents: strongly-taken when hi+lo is odd, otherwise weak by op bit 0.
    function automatic logic [1:0] ram(input logic [11:0] a);
        logic [4:0] s;
        s = {1'b0, a[11:8]} + {1'b0, a[3:0]};
        if (s[0]) return 2'b11;
        return {a[4], ~a[4]};
    endfunction

    assign rd0 = ram(ra0);
    assign rd1 = ram(ra1);
    assign rd2 = ram(ra2);
    assign rd3 = ram(ra3);

    typedef struct {
        logic [47:0] addrs;
        logic [7:0]  pred;
        logic [3:0]  take;
        logic [1:0]  first;
        logic        any;
        int          acc;
    } bund_t;

    typedef struct {
        logic [2:0] tag;
        logic [3:0] take;
    } ent_t;

    bund_t expq[$];   // accepted, not yet emitted, oldest first
    ent_t  mq[$];     // emitted, not yet resolved
    int    m_tag, m_mis, cyc;
    bit    m_err, m_on;
    int    n_cmp, n_bad;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bund_t mk(input logic [3:0] en, input logic [15:0] hi, op, lo,
                                 input int acc);
        bund_t b;
        logic [11:0] a;
        logic [1:0] p;
        b.addrs = '0; b.pred = '0; b.take = '0; b.first = '0; b.acc = acc;
        for (int n = 0; n < 4; n++) begin
            a = {hi[4*n +: 4], op[4*n +: 4], lo[4*n +: 4]};
            p = en[n] ? ram(a) : 2'b00;
            if (en[n]) b.addrs[12*n +: 12] = a;
            b.pred[2*n +: 2] = p;
            b.take[n] = en[n] && (p == 2'b11);
        end
        for (int n = 3; n >= 0; n--) if (b.take[n]) b.first = 2'(n);
        b.any = |b.take;
        return b;
    endfunction

    // Reference model and per-cycle compare; handshakes seen here take effect at the next edge.
    always @(negedge clk) begin
        bit s1v, s2v, fire;
        logic [47:0] ea;
        bund_t b;
        ent_t e;
        if (m_on) begin
            s2v = (expq.size() > 0) && (cyc - expq[0].acc >= 2);
            s1v = (expq.size() == 2) || ((expq.size() == 1) && !s2v);
            chk("pending_cnt", pending_cnt, mq.size());
            chk("mispredict_cnt", mispredict_cnt, m_mis);
            chk("err", err, m_err);
            chk("out_valid", out_valid, s2v && (mq.size() < 8));
            fire = out_valid && out_ready;
            chk("in_ready", in_ready, !s1v || !s2v || fire);
            ea = s1v ? expq[expq.size()-1].addrs : '0;
            chk("read_addr", {ra3, ra2, ra1, ra0} == ea, 1);
            if (out_valid && expq.size() > 0) begin
                chk("out_pred", out_pred, expq[0].pred);
                chk("out_take", out_take, expq[0].take);
                chk("out_first", out_first, expq[0].first);
                chk("out_any", out_any, expq[0].any);
                chk("out_tag", out_tag, m_tag);
            end
            if (rst) begin
                expq.delete(); mq.delete(); m_tag = 0; m_mis = 0; m_err = 0;
            end else begin
                if (res_valid) begin
                    if (mq.size() == 0) m_err = 1;
                    else begin
                        e = mq.pop_front();
                        if (res_tag != e.tag) m_err = 1;
                        if (res_taken != e.take && m_mis != 65535) m_mis++;
                    end
                end
                if (fire && expq.size() > 0) begin
                    b = expq.pop_front();
                    mq.push_back('{tag: 3'(m_tag), take: b.take});
                    m_tag = (m_tag + 1) % 8;
                end
                if (in_valid && in_ready)
                    expq.push_back(mk(in_slot_en, in_hi, in_op, in_lo, cyc));
            end
        end else if (rst) begin
            m_on = 1;
            expq.delete(); mq.delete(); m_tag = 0; m_mis = 0; m_err = 0;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; res_valid = 0; res_tag = 0; res_taken = 0;
        in_slot_en = 0; in_hi = 0; in_op = 0; in_lo = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1; tick(); tick();
        rst = 0;
    endtask

    task automatic drive(input logic [3:0] en, input logic [15:0] hi, op, lo);
        in_valid = 1; in_slot_en = en; in_hi = hi; in_op = op; in_lo = lo;
    endtask

    task automatic resolve_all();
        for (int i = 0; i < 40 && mq.size() > 0; i++) begin
            res_valid = 1; res_tag = mq[0].tag; res_taken = mq[0].take;
            tick();
            res_valid = 0;
        end
        chk("drain_queue", mq.size(), 0);
    endtask

    // Feed bundles until k more have been accepted, within a cycle budget.
    task automatic feed(input int k, input logic [3:0] en, input logic [15:0] hi, op, lo);
        int got = 0;
        drive(en, hi, op, lo);
        for (int i = 0; i < 60 && got < k; i++) begin
            if (in_ready) got++;
            tick();
        end
        in_valid = 0;
        chk("feed_accepts", got, k);
    endtask

    task automatic wait_pending(input int k);
        for (int i = 0; i < 40 && pending_cnt != 4'(k); i++) tick();
        chk("wait_pending", pending_cnt, k);
    endtask

    initial begin
        logic [7:0] held;
        n_cmp = 0; n_bad = 0; cyc = 0; m_on = 0;
        out_ready = 1;
        do_reset();
        tick();

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_pending", pending_cnt, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_pred", out_pred, 0);

        // Single bundle
        drive(4'b0001, 16'h0000, 16'h0008, 16'h0001);
        tick(); idle();
        chk("single_addr0", ra0, 12'h081);
        chk("single_addr1", ra1, 12'h000);
        tick();
        chk("single_valid", out_valid, 1);
        chk("single_pred", out_pred, 8'b0000_0011);
        chk("single_take", out_take, 4'b0001);
        chk("single_first", out_first, 0);
        chk("single_tag", out_tag, 0);
        tick();
        chk("single_pending", pending_cnt, 1);
        res_valid = 1; res_tag = 0; res_taken = 4'b0001;
        tick(); idle();
        chk("single_pending0", pending_cnt, 0);
        chk("single_mis", mispredict_cnt, 0);

        // All slots enabled
        drive(4'hF, 16'h2222, 16'h8888, 16'h2222);
        tick(); idle(); tick();
        chk("all_take", out_take, 4'b0000);
        chk("all_any", out_any, 0);
        chk("all_pred", out_pred, 8'h55);
        tick();
        drive(4'hF, 16'h2222, 16'h8888, 16'h2122);
        tick(); idle(); tick();
        chk("slot2_take", out_take, 4'b0100);
        chk("slot2_first", out_first, 2);
        chk("slot2_pred", out_pred, 8'h75);
        tick();
        resolve_all();

        // Backpressure
        do_reset();
        out_ready = 0;
        drive(4'hF, 16'h1234, 16'h5678, 16'h9ABC);
        tick(); tick();
        chk("bp_in_ready", in_ready, 0);
        held = out_pred;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("bp_hold", out_pred, held);
            chk("bp_in_ready_low", in_ready, 0);
        end
        out_ready = 1;
        feed(2, 4'b1010, 16'h3131, 16'h0F0F, 16'h4242);
        wait_pending(4);
        resolve_all();

        // Queue full, then mispredict and error cases
        do_reset();
        feed(9, 4'b0001, 16'h0000, 16'h0008, 16'h0001);
        tick(); tick(); tick();
        chk("full_pending", pending_cnt, 8);
        chk("full_out_valid", out_valid, 0);
        res_valid = 1; res_tag = 0; res_taken = 4'b0001;
        tick(); res_valid = 0;
        chk("full_issue_valid", out_valid, 1);
        chk("full_issue_tag", out_tag, 0);
        tick();
        chk("full_refill", pending_cnt, 8);
        res_valid = 1; res_tag = 1; res_taken = 4'b0000;
        tick(); res_valid = 0;
        chk("mis_count", mispredict_cnt, 1);
        chk("mis_pending", pending_cnt, 7);
        res_valid = 1; res_tag = 5; res_taken = 4'b0001;
        tick(); res_valid = 0;
        chk("badtag_err", err, 1);
        chk("badtag_pop", pending_cnt, 6);
        resolve_all();
        res_valid = 1; res_tag = 0; res_taken = 0;
        tick(); res_valid = 0;
        chk("empty_err", err, 1);
        chk("empty_pending", pending_cnt, 0);
        chk("empty_mis", mispredict_cnt, 1);

        // Reset mid-stream with 3 pending and S1/S2 full
        do_reset();
        feed(3, 4'b0011, 16'h0011, 16'h0000, 16'h0010);
        wait_pending(3);
        out_ready = 0;
        drive(4'hF, 16'h0101, 16'h0202, 16'h0303);
        tick(); tick();
        rst = 1; out_ready = 1; res_valid = 1; res_tag = mq[0].tag; res_taken = 0;
        tick();
        rst = 0; idle();
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_pending", pending_cnt, 0);
        chk("mrst_tag", out_tag, 0);
        chk("mrst_err", err, 0);
        chk("mrst_addr", ra0, 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            in_valid   = ($urandom_range(3) != 0);
            in_slot_en = 4'($urandom);
            in_hi      = 16'($urandom);
            in_op      = 16'($urandom);
            in_lo      = 16'($urandom);
            out_ready  = ($urandom_range(9) < 7);
            res_valid  = 0;
            if (mq.size() > 0 && $urandom_range(9) < 3) begin
                res_valid = 1;
                res_tag   = ($urandom_range(19) == 0) ? 3'($urandom) : mq[0].tag;
                res_taken = ($urandom_range(4) == 0) ? 4'($urandom) : mq[0].take;
            end else if ($urandom_range(99) == 0) begin
                res_valid = 1; res_tag = 3'($urandom); res_taken = 4'($urandom);
            end
            rst = ($urandom_range(499) == 0);
            tick();
        end
        rst = 0; idle(); out_ready = 1;
        tick(); tick(); tick();
        resolve_all();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
